// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_ALU = 2'b01, OP_LOAD = 2'b10, OP_BR = 2'b11} op_t;
  typedef enum logic [1:0] {FW_RF = 2'b00, FW_EXE = 2'b01, FW_MEM = 2'b10, FW_LD = 2'b11} fw_t;
  typedef enum logic [1:0] {RUN, LD_STALL, MC_BUSY} state_t;
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: operand source select for one ID operand, youngest producer first.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              used,
  input  logic [REG_AW-1:0] rd_exe,
  input  logic [1:0]        op_exe,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic [1:0]        op_mem,
  output logic [1:0]        sel,
  output logic              ld_hit
);
  logic live, hit_exe, hit_mem;
  assign live    = used && rs != '0;
  assign hit_exe = live && rs == rd_exe;
  assign hit_mem = live && rs == rd_mem;
  assign ld_hit  = hit_exe && op_exe == OP_LOAD;
  assign sel = (hit_exe && op_exe == OP_ALU)  ? FW_EXE :
               (hit_mem && op_mem == OP_ALU)  ? FW_MEM :
               (hit_mem && op_mem == OP_LOAD) ? FW_LD  : FW_RF;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: forwarding selects, load-use/mul-div stall engine, mispredict flush and
// saturating stall/flush counters for the 5-stage pipeline.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int LD_STALL_CYC = 1,
  parameter int MC_LAT       = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [1:0]        optype_ID,
  input  logic              mc_start_ID,
  input  logic [REG_AW-1:0] rd_EXE,
  input  logic [REG_AW-1:0] rd_MEM,
  input  logic [1:0]        optype_EXE,
  input  logic [1:0]        optype_MEM,
  input  logic [REG_AW-1:0] rs2_EXE,
  input  logic              store_EXE,
  input  logic              mispredict_EXE,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_EN,
  output logic              reg_DE_flush,
  output logic              reg_EM_EN,
  output logic              reg_EM_flush,
  output logic              reg_MW_EN,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [1:0] sel_a, sel_b;
  logic       ld_a, ld_b, ld_haz, flush, unused_optype;
  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(rs1_ID), .used(rs1use_ID), .rd_exe(rd_EXE), .op_exe(optype_EXE),
    .rd_mem(rd_MEM), .op_mem(optype_MEM), .sel(sel_a), .ld_hit(ld_a)
  );
  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(rs2_ID), .used(rs2use_ID), .rd_exe(rd_EXE), .op_exe(optype_EXE),
    .rd_mem(rd_MEM), .op_mem(optype_MEM), .sel(sel_b), .ld_hit(ld_b)
  );
  // operand usage arrives pre-decoded in rs*use_ID, so the ID optype carries no extra hazard info
  assign unused_optype   = ^optype_ID;
  assign forward_ctrl_A  = rst_n ? sel_a : FW_RF;
  assign forward_ctrl_B  = rst_n ? sel_b : FW_RF;
  assign forward_ctrl_ls = store_EXE && rs2_EXE != '0 && rs2_EXE == rd_MEM && optype_MEM == OP_LOAD;
  assign ld_haz = rst_n && (ld_a || ld_b);
  // a mispredict seen during mul/div belongs to a younger branch still queued behind it
  assign flush = rst_n && mispredict_EXE && state != MC_BUSY;
  assign busy  = state != RUN;
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    PC_EN_IF     = 1'b1;
    reg_FD_EN    = 1'b1;
    reg_FD_flush = 1'b0;
    reg_DE_EN    = 1'b1;
    reg_DE_flush = 1'b0;
    reg_EM_EN    = 1'b1;
    reg_EM_flush = 1'b0;
    reg_MW_EN    = 1'b1;
    if (flush) begin
      state_nx     = RUN;
      cnt_nx       = '0;
      reg_FD_flush = 1'b1;
      reg_DE_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ld_haz) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_DE_flush = 1'b1;
            // the detecting cycle is the first bubble; the state covers the rest
            if (LD_STALL_CYC > 1) begin
              state_nx = LD_STALL;
              cnt_nx   = 4'(LD_STALL_CYC - 2);
            end
          end else if (mc_start_ID) begin
            state_nx = MC_BUSY;
            cnt_nx   = 4'(MC_LAT - 1);
          end
        end
        LD_STALL: begin
          PC_EN_IF     = 1'b0;
          reg_FD_EN    = 1'b0;
          reg_DE_flush = 1'b1;
          if (cnt == '0) state_nx = RUN;
          else cnt_nx = cnt - 4'd1;
        end
        MC_BUSY: begin
          PC_EN_IF     = 1'b0;
          reg_FD_EN    = 1'b0;
          reg_DE_EN    = 1'b0;
          reg_EM_flush = 1'b1;
          if (cnt == '0) state_nx = RUN;
          else cnt_nx = cnt - 4'd1;
        end
        default: state_nx = RUN;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (!PC_EN_IF && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed vectors for the hazard controller; a second instance uses a
// 2-cycle load stall and 2-bit counters to cover the LD_STALL state and saturation.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;
  logic       clk = 1'b0, rst_n;
  logic [4:0] rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE;
  logic       rs1use_ID, rs2use_ID, mc_start_ID, store_EXE, mispredict_EXE;
  logic [1:0] optype_ID, optype_EXE, optype_MEM;
  logic        pc_en, fd_en, fd_fl, de_en, de_fl, em_en, em_fl, mw_en, ls, bsy;
  logic [1:0]  fw_a, fw_b;
  logic [15:0] st_cnt, fl_cnt;
  logic        s_pc_en, s_fd_en, s_fd_fl, s_de_en, s_de_fl, s_em_en, s_em_fl, s_mw_en, s_ls, s_bsy;
  logic [1:0]  s_fw_a, s_fw_b, s_st_cnt, s_fl_cnt;
  int n_vec = 0, n_err = 0;
  hazard_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1use_ID(rs1use_ID),
    .rs2use_ID(rs2use_ID), .optype_ID(optype_ID), .mc_start_ID(mc_start_ID), .rd_EXE(rd_EXE),
    .rd_MEM(rd_MEM), .optype_EXE(optype_EXE), .optype_MEM(optype_MEM), .rs2_EXE(rs2_EXE),
    .store_EXE(store_EXE), .mispredict_EXE(mispredict_EXE), .PC_EN_IF(pc_en), .reg_FD_EN(fd_en),
    .reg_FD_flush(fd_fl), .reg_DE_EN(de_en), .reg_DE_flush(de_fl), .reg_EM_EN(em_en),
    .reg_EM_flush(em_fl), .reg_MW_EN(mw_en), .forward_ctrl_A(fw_a), .forward_ctrl_B(fw_b),
    .forward_ctrl_ls(ls), .busy(bsy), .stall_cnt(st_cnt), .flush_cnt(fl_cnt)
  );
  hazard_ctrl_unit #(.LD_STALL_CYC(2), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1use_ID(rs1use_ID),
    .rs2use_ID(rs2use_ID), .optype_ID(optype_ID), .mc_start_ID(mc_start_ID), .rd_EXE(rd_EXE),
    .rd_MEM(rd_MEM), .optype_EXE(optype_EXE), .optype_MEM(optype_MEM), .rs2_EXE(rs2_EXE),
    .store_EXE(store_EXE), .mispredict_EXE(mispredict_EXE), .PC_EN_IF(s_pc_en), .reg_FD_EN(s_fd_en),
    .reg_FD_flush(s_fd_fl), .reg_DE_EN(s_de_en), .reg_DE_flush(s_de_fl), .reg_EM_EN(s_em_en),
    .reg_EM_flush(s_em_fl), .reg_MW_EN(s_mw_en), .forward_ctrl_A(s_fw_a), .forward_ctrl_B(s_fw_b),
    .forward_ctrl_ls(s_ls), .busy(s_bsy), .stall_cnt(s_st_cnt), .flush_cnt(s_fl_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle;
    rs1_ID = '0; rs2_ID = '0; rd_EXE = '0; rd_MEM = '0; rs2_EXE = '0;
    rs1use_ID = 0; rs2use_ID = 0; mc_start_ID = 0; store_EXE = 0; mispredict_EXE = 0;
    optype_ID = OP_NONE; optype_EXE = OP_NONE; optype_MEM = OP_NONE;
  endtask
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask
  task automatic load_use;
    idle;
    rs2_ID = 5'd6; rs2use_ID = 1; rd_EXE = 5'd6; optype_EXE = OP_LOAD;
  endtask
  task automatic load_in_mem;
    idle;
    rs2_ID = 5'd6; rs2use_ID = 1; rd_MEM = 5'd6; optype_MEM = OP_LOAD;
  endtask
  initial begin
    rst_n = 0;
    idle;
    rs1_ID = 5'd5; rs1use_ID = 1; rd_EXE = 5'd5; optype_EXE = OP_ALU; mispredict_EXE = 1;
    #3;
    chk("rst_fwd_a", fw_a, 2'b00);
    chk("rst_fd_flush", fd_fl, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_busy", bsy, 0);
    chk("rst_stall_cnt", st_cnt, 0);
    #4 rst_n = 1; mispredict_EXE = 0;
    #1 chk("fwd_a_exe_alu", fw_a, 2'b01);
    chk("fwd_no_stall", pc_en, 1);
    rs1_ID = 0; rd_EXE = 0;
    #1 chk("fwd_a_x0", fw_a, 2'b00);
    cyc;
    idle;
    rs2_ID = 5'd9; rs2use_ID = 1; rd_EXE = 5'd9; optype_EXE = OP_ALU; rd_MEM = 5'd9; optype_MEM = OP_ALU;
    #1 chk("fwd_b_exe_prio", fw_b, 2'b01);
    rd_EXE = 5'd3;
    #1 chk("fwd_b_mem_alu", fw_b, 2'b10);
    optype_MEM = OP_LOAD;
    #1 chk("fwd_b_mem_ld", fw_b, 2'b11);
    rs2use_ID = 0;
    #1 chk("fwd_b_unused", fw_b, 2'b00);
    cyc;
    idle;
    rs1_ID = 5'd9; rs1use_ID = 1; rd_EXE = 5'd9; optype_EXE = OP_BR; rd_MEM = 5'd9; optype_MEM = OP_ALU;
    #1 chk("fwd_a_skip_branch", fw_a, 2'b10);
    idle;
    store_EXE = 1; rs2_EXE = 5'd7; rd_MEM = 5'd7; optype_MEM = OP_LOAD;
    #1 chk("ls_fwd", ls, 1);
    rs2_EXE = 0; rd_MEM = 0;
    #1 chk("ls_x0", ls, 0);
    cyc;
    load_use;
    #1 chk("lu_pc_en", pc_en, 0);
    chk("lu_fd_en", fd_en, 0);
    chk("lu_de_flush", de_fl, 1);
    chk("lu_de_en", de_en, 1);
    chk("lu_busy", bsy, 0);
    chk("lu_s_pc_en", s_pc_en, 0);
    cyc;
    load_in_mem;
    #1 chk("lu_fwd_b_ld", fw_b, 2'b11);
    chk("lu_resume", pc_en, 1);
    chk("lu_stall_cnt", st_cnt, 1);
    chk("lu_s_pc_en2", s_pc_en, 0);
    chk("lu_s_busy", s_bsy, 1);
    chk("lu_s_de_flush", s_de_fl, 1);
    chk("lu_s_stall_cnt", s_st_cnt, 1);
    cyc;
    idle;
    #1 chk("lu_s_done", s_bsy, 0);
    chk("lu_s_resume", s_pc_en, 1);
    chk("lu_s_stall_cnt2", s_st_cnt, 2);
    load_use;
    mispredict_EXE = 1;
    #1 chk("mpa_pc_en", pc_en, 1);
    chk("mpa_fd_flush", fd_fl, 1);
    chk("mpa_de_flush", de_fl, 1);
    chk("mpa_fd_en", fd_en, 1);
    chk("mpa_s_pc_en", s_pc_en, 1);
    cyc;
    idle;
    #1 chk("mpa_flush_cnt", fl_cnt, 1);
    chk("mpa_stall_cnt", st_cnt, 1);
    chk("mpa_s_busy", s_bsy, 0);
    load_use;
    cyc;
    load_in_mem;
    mispredict_EXE = 1;
    #1 chk("mpb_s_pc_en", s_pc_en, 1);
    chk("mpb_s_fd_flush", s_fd_fl, 1);
    chk("mpb_s_de_flush", s_de_fl, 1);
    cyc;
    idle;
    #1 chk("mpb_s_busy", s_bsy, 0);
    chk("mpb_flush_cnt", fl_cnt, 2);
    chk("mpb_s_flush_cnt", s_fl_cnt, 2);
    chk("mpb_stall_cnt", st_cnt, 2);
    chk("mpb_s_stall_cnt", s_st_cnt, 3);
    mc_start_ID = 1;
    #1 chk("mc_entry_pc_en", pc_en, 1);
    chk("mc_entry_busy", bsy, 0);
    cyc;
    idle;
    for (int i = 0; i < 4; i++) begin
      mispredict_EXE = (i == 1);
      #1 chk("mc_pc_en", pc_en, 0);
      chk("mc_em_flush", em_fl, 1);
      chk("mc_de_en", de_en, 0);
      chk("mc_mw_en", mw_en, 1);
      chk("mc_busy", bsy, 1);
      chk("mc_fd_flush", fd_fl, 0);
      chk("mc_s_stall_sat", s_st_cnt, 3);
      cyc;
    end
    mispredict_EXE = 0;
    #1 chk("mc_done_busy", bsy, 0);
    chk("mc_done_pc_en", pc_en, 1);
    chk("mc_stall_cnt", st_cnt, 6);
    chk("mc_flush_ignored", fl_cnt, 2);
    mc_start_ID = 1;
    cyc;
    mc_start_ID = 0;
    cyc;
    #1 chk("ar_busy_before", bsy, 1);
    rst_n = 0;
    #1 chk("ar_pc_en", pc_en, 1);
    chk("ar_em_flush", em_fl, 0);
    chk("ar_de_en", de_en, 1);
    chk("ar_busy", bsy, 0);
    chk("ar_stall_cnt", st_cnt, 0);
    chk("ar_flush_cnt", fl_cnt, 0);
    cyc;
    rst_n = 1;
    cyc;
    #1 chk("ar_after_busy", bsy, 0);
    chk("ar_after_pc_en", pc_en, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
